// File: rtl/chip8_pkg.sv
// chip8_pkg -- shared definitions for the CHIP-8 keypad scanner.
//
// Contents:
//   KEY_W      width of a CHIP-8 key code (one hex digit)
//   NUM_KEYS   number of keys on the 4x4 matrix
//   key_idx_t  type of a hex key code
//   KEY_MAP    matrix position (row*4 + col) -> hex key code
//   row_drive  active-low one-hot row drive pattern for a row index
package chip8_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = 16;

  typedef logic [KEY_W-1:0] key_idx_t;

  // Physical layout of the COSMAC VIP style keypad, row-major.
  //   row0: 1 2 3 C   row1: 4 5 6 D   row2: 7 8 9 E   row3: A 0 B F
  localparam key_idx_t KEY_MAP [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/chip8_key_debounce.sv
// chip8_key_debounce -- debounced state of one keypad key.
//
// Configuration macro: CHIP8_KEYPAD_DEBOUNCE_EN
//   defined   : an agreement counter must see DEBOUNCE_SCANS consecutive
//               samples that differ from the current state before it flips.
//   undefined : no counter; the state simply follows the raw sample.
//
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   en_i       sample strobe (this key's row is being sampled this cycle)
//   raw_i      raw pressed level for this key (1 = pressed)
//   state_o    registered debounced state
//   state_d_o  debounced state that will be loaded on this edge, used by the
//              parent to spot 0->1 transitions in the same cycle they happen
module chip8_key_debounce
  import chip8_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_i,
  input  logic raw_i,
  output logic state_o,
  output logic state_d_o
);

  logic state_q, state_d;

`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      if (raw_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        // This disagreeing sample is the DEBOUNCE_SCANS-th in a row.
        state_d = raw_i;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Filtering disabled: the depth parameter has no effect in this build.
  logic [31:0] cfg_unused;
  assign cfg_unused = 32'(DEBOUNCE_SCANS);

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = raw_i;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  assign state_o   = state_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/chip8_keypad.sv
// chip8_keypad -- 4x4 matrix keypad scanner for a CHIP-8 core.
//
// Drives one row low at a time for SCAN_DIV cycles, samples the synchronized
// columns on the last dwell cycle, debounces each key and reports new key
// presses through a single-entry valid/ready event register.
//
// Configuration macro: CHIP8_KEYPAD_DEBOUNCE_EN (enables per-key agreement
// counters of depth DEBOUNCE_SCANS; otherwise keys follow the raw samples).
//
// Ports:
//   clk_in     system clock (single domain)
//   rst_in     synchronous active-high reset
//   col_in     [3:0] keypad columns, active-low, asynchronous
//   row_out    [3:0] keypad row drive, active-low one-hot
//   key_state  [15:0] debounced pressed state, indexed by hex key value
//   evt_valid  a key-press event is pending
//   evt_key    [3:0] hex value of the pending press
//   evt_ready  consumer accepts the pending event
module chip8_keypad
  import chip8_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [3:0]        col_in,
  output logic [3:0]        row_out,
  output logic [15:0]       key_state,
  output logic              evt_valid,
  output logic [KEY_W-1:0]  evt_key,
  input  logic              evt_ready
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [3:0]       col_s1_q, col_s2_q;
  logic [1:0]       row_q, row_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             sample_stb;

  logic [NUM_KEYS-1:0] pos_state;     // debounced state by matrix position
  logic [NUM_KEYS-1:0] pos_state_nx;  // same, value loaded on this edge
  logic [NUM_KEYS-1:0] rise_hex;      // 0->1 transitions by hex value
  logic                any_rise;
  key_idx_t            rise_key;

  logic     evt_valid_q, evt_valid_d;
  key_idx_t evt_key_q, evt_key_d;

  // Row scan timing: the last dwell cycle of a row is the sample cycle, and
  // the row advances on that same edge.
  assign sample_stb = (dwell_q == DW'(SCAN_DIV - 1));

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    row_d   = row_q;
    if (sample_stb) begin
      dwell_d = '0;
      row_d   = row_q + 2'd1;
    end
  end

  assign row_out = row_drive(row_q);

  // One debouncer per matrix position; only the active row is enabled.
  // Column lines are active-low, so a low synchronized column is a press.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      chip8_key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) u_deb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_i      (sample_stb && (row_q == 2'(gi / 4))),
        .raw_i     (~col_s2_q[gi % 4]),
        .state_o   (pos_state[gi]),
        .state_d_o (pos_state_nx[gi])
      );
    end
  endgenerate

  // Reorder from matrix position to hex key value.
  always_comb begin
    key_state = '0;
    rise_hex  = '0;
    for (int p = 0; p < NUM_KEYS; p++) begin
      key_state[KEY_MAP[p]] = pos_state[p];
      rise_hex[KEY_MAP[p]]  = pos_state_nx[p] & ~pos_state[p];
    end
  end

  // Lowest hex value wins when several keys go down on one sample edge.
  always_comb begin
    any_rise = |rise_hex;
    rise_key = '0;
    for (int h = NUM_KEYS - 1; h >= 0; h--) begin
      if (rise_hex[h]) begin
        rise_key = key_idx_t'(h);
      end
    end
  end

  // Single-entry event register. A new press is only loaded when the slot is
  // empty or being emptied on this edge; otherwise it is dropped so the
  // pending key stays stable for the consumer.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (any_rise && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_key_d   = rise_key;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_s1_q    <= 4'b1111;
      col_s2_q    <= 4'b1111;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
    end else begin
      col_s1_q    <= col_in;
      col_s2_q    <= col_s1_q;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;

endmodule

// File: tb/tb_chip8_keypad.sv
// tb_chip8_keypad -- self-checking bench for chip8_keypad (SCAN_DIV=4,
// DEBOUNCE_SCANS=3). A behavioural key matrix drives col_in from row_out and
// the set of held keys. Expected events go into a queue; a monitor pops and
// compares on every accepted transfer. Expectations follow the macro setting
// (three agreeing scans when CHIP8_KEYPAD_DEBOUNCE_EN is defined, one otherwise).
module tb_chip8_keypad;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
  localparam int NEFF = DEB;
`else
  localparam int NEFF = 1;
`endif
  // Edge (counted from reset release) on which a key held from cycle 0 is
  // first reported: row r is sampled on edge 4*(r+1), then every 16 cycles.
  localparam int ROW0_HIT = 4 + 16 * (NEFF - 1);
  localparam int ROW1_HIT = 8 + 16 * (NEFF - 1);
  localparam int ROW3_HIT = 16 + 16 * (NEFF - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_state;
  logic        evt_valid;
  logic [3:0]  evt_key;
  logic        evt_ready = 1'b0;

  logic [15:0] pressed = '0;   // held keys, indexed by hex value
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q [$];

  localparam logic [3:0] HEX_AT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hC, 4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE, 4'hA, 4'h0, 4'hB, 4'hF
  };
  localparam logic [3:0] ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  chip8_keypad #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_ready (evt_ready)
  );

  always #5 clk = ~clk;

  // Key matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int p = 0; p < 16; p++) begin
      if (pressed[HEX_AT[p]] && !row_out[p / 4]) begin
        col_in[p % 4] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cyc %0d)", name, act, cyc);
    end
  endtask

  // Advance to just after clock edge k (counted from reset release).
  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc != k && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) chk("wait_timeout", cyc, k);
  endtask

  task automatic reset_dut();
    evt_ready = 1'b0;
    pressed   = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted transfer must match the queue head.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL evt_unexpected: got key 0x%0h, expected no event (cyc %0d)", evt_key, cyc);
      end else begin
        chk("evt_key_xfer", evt_key, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and row rotation.
    reset_dut();
    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key_state", key_state, 16'h0000);
    chk("rst_evt_valid", evt_valid, 0);
    for (int k = 0; k < 16; k++) begin
      wait_cyc(k);
      chk($sformatf("row_out_k%0d", k), row_out, ROWS[(k / 4) % 4]);
    end
    chk("idle_key_state", key_state, 16'h0000);
    chk("idle_evt_valid", evt_valid, 0);

    // Key 5 held: reported after the required number of row-1 samples.
    reset_dut();
    pressed[5] = 1'b1;
    wait_cyc(ROW1_HIT - 1);
    chk("A_key_state_before", key_state, 16'h0000);
    chk("A_evt_valid_before", evt_valid, 0);
    wait_cyc(ROW1_HIT);
    chk("A_key_state", key_state, 16'h0020);
    chk("A_evt_valid", evt_valid, 1);
    chk("A_evt_key", evt_key, 5);
    exp_q.push_back(4'h5);
    evt_ready = 1'b1;
    wait_cyc(ROW1_HIT + 1);
    chk("A_evt_valid_after_accept", evt_valid, 0);
    evt_ready = 1'b0;

    // Key 5 held for two row-1 samples then released.
    reset_dut();
    evt_ready  = 1'b1;
    pressed[5] = 1'b1;
    if (NEFF <= 2) exp_q.push_back(4'h5);
    wait_cyc(30);
    pressed[5] = 1'b0;
    wait_cyc(41);
    chk("B_key_state", key_state, 16'h0000);
    chk("B_evt_valid", evt_valid, 0);
    chk("B_events_left", exp_q.size(), 0);

    // Stalled consumer: 5 then A; pending key must stay 5.
    reset_dut();
    pressed[5]  = 1'b1;
    pressed[10] = 1'b1;
    wait_cyc(ROW3_HIT);
    chk("C_key_state", key_state, 16'h0420);
    chk("C_evt_valid", evt_valid, 1);
    chk("C_evt_key", evt_key, 5);
    exp_q.push_back(4'h5);
    evt_ready = 1'b1;
    wait_cyc(ROW3_HIT + 1);
    chk("C_evt_valid_after_accept", evt_valid, 0);
    wait_cyc(ROW3_HIT + 40);
    chk("C_evt_valid_late", evt_valid, 0);
    chk("C_events_left", exp_q.size(), 0);

    // Keys 1 and 2 together: lowest value reported.
    reset_dut();
    pressed[1] = 1'b1;
    pressed[2] = 1'b1;
    wait_cyc(ROW0_HIT);
    chk("D_key_state", key_state, 16'h0006);
    chk("D_evt_valid", evt_valid, 1);
    chk("D_evt_key", evt_key, 1);
    exp_q.push_back(4'h1);
    evt_ready = 1'b1;
    wait_cyc(ROW0_HIT + 1);
    chk("D_evt_valid_after_accept", evt_valid, 0);

    // Reset pulse mid-debounce of key 5.
    reset_dut();
    pressed[5] = 1'b1;
    wait_cyc(30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("E_row_out", row_out, 4'b1110);
    chk("E_key_state", key_state, 16'h0000);
    chk("E_evt_valid", evt_valid, 0);
    wait_cyc(ROW1_HIT - 1);
    chk("E_key_state_before", key_state, 16'h0000);
    wait_cyc(ROW1_HIT);
    chk("E_key_state", key_state, 16'h0020);
    chk("E_evt_key", evt_key, 5);
    exp_q.push_back(4'h5);
    evt_ready = 1'b1;
    wait_cyc(ROW1_HIT + 1);
    chk("E_evt_valid_after_accept", evt_valid, 0);

    chk("final_events_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chip8_keypad.md
CHIP8_KEYPAD -- requirements
Module: chip8_keypad

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each row is driven (dwell); legal range is 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive agreeing samples of a key before its debounced state changes; legal range is 1 or more.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; all logic in this clock domain.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port col_in, input, 4 bits: keypad columns, active-low, asynchronous (externally pulled up).
REQ-006 SHALL have port row_out, output, 4 bits: keypad row drive, active-low, one-hot-low.
REQ-007 SHALL have port key_state, output, 16 bits: debounced pressed state, indexed by CHIP-8 hex key value.
REQ-008 SHALL have port evt_valid, output, 1 bit: a key-press event is pending.
REQ-009 SHALL have port evt_key, output, 4 bits: hex value of the pending press.
REQ-010 SHALL have port evt_ready, input, 1 bit: the consumer (CPU Fx0A wait) accepts the event.

Function
REQ-011 SHALL pass col_in through a 2-flop synchronizer before any use.
REQ-012 SHALL drive exactly one row low at a time, rotating 0,1,2,3,0…; each row is held for SCAN_DIV cycles.
REQ-013 SHALL sample the synchronized columns on the last dwell cycle of each row (dwell count = SCAN_DIV-1); all key updates occur on that clock edge.
REQ-014 SHALL map (row,col) to hex as follows: row0 = 1,2,3,C; row1 = 4,5,6,D; row2 = 7,8,9,E; row3 = A,0,B,F (col0..col3).
REQ-015 SHALL treat a low sampled column as raw pressed; only the 4 keys of the active row update per sample.
REQ-016 SHALL keep a per-key agreement counter: a sample differing from the debounced state increments it, and an agreeing sample clears it; reaching DEBOUNCE_SCANS flips the debounced state and clears the counter.
REQ-017 SHALL raise a press event on a debounced 0->1 transition; key_state and evt_valid/evt_key become visible on the same cycle, one cycle after the sample edge.
REQ-018 SHALL implement the event handshake as a single-entry register: an event transfers when evt_valid && evt_ready, and evt_valid deasserts on the following cycle unless a new press is captured on that edge.
REQ-019 SHALL hold evt_key stable while evt_valid=1 and evt_ready=0; new presses in that interval are discarded, while key_state still updates.
REQ-020 SHALL capture only the lowest hex value when several keys become pressed on one sample edge.
REQ-021 SHALL generate no event on release (1->0).
REQ-022 SHALL, on simultaneous acceptance and a new press on the same edge, keep evt_valid=1 and load the new key.

Reset
REQ-023 SHALL, while rst_in=1 at a clock edge, set the following: row_out=4'b1110, row index 0, dwell counter 0, synchronizer flops 4'b1111, key_state=0, all agreement counters 0, evt_valid=0, evt_key=0.
REQ-024 SHALL discard any pending event or partial debounce on reset mid-operation; scanning restarts at row 0 on the first cycle after rst_in falls.

Configuration
REQ-025 SHALL honour macro CHIP8_KEYPAD_DEBOUNCE_EN; when it is defined, REQ-016 applies.
REQ-026 SHALL, when CHIP8_KEYPAD_DEBOUNCE_EN is undefined, omit the agreement counters; the debounced state equals the raw sample on each sample edge (latency otherwise unchanged) and DEBOUNCE_SCANS is ignored.

Structure
REQ-027 SHALL take the following from shared package chip8_pkg: KEY_W=4, the 4x4 row/col-to-hex map constant, and the key index typedef.
REQ-028 SHALL instantiate 16 copies of sub-module chip8_key_debounce (one agreement counter plus state bit, enable = row-sample strobe).

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, macro defined; full scan = 16 cycles)
REQ-029 SHALL cover the following: after reset, row_out cycles 1110,1101,1011,0111 every 4 cycles; key_state=0 and evt_valid=0.
REQ-030 SHALL cover the following: col_in[1] held low while row1 is driven, for 3 scans -> key_state[5]=1 and evt_valid=1 with evt_key=5 after the third row-1 sample; evt_ready=1 -> evt_valid=0 next cycle.
REQ-031 SHALL cover the following: key 5 held for 2 scans, then released -> no event and key_state[5] stays 0; the same stimulus with the macro undefined -> event with evt_key=5.
REQ-032 SHALL cover the following: evt_ready=0, press 5 then A -> evt_key stays 5, key_state[5] and key_state[10] both 1; raising evt_ready yields no second event.
REQ-033 SHALL cover the following: keys 1 and 2 (row0, col0/col1) pressed together -> evt_key=1 and key_state[1]=key_state[2]=1.
REQ-034 SHALL cover the following: rst_in pulsed mid-debounce of key 5 -> next cycle row_out=1110, key_state=0, evt_valid=0; the press needs 3 fresh scans.
